// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter that funnels NREQ requesters onto one APB master command port.
// Define APB_ARB_FIXED_PRIO_EN for fixed priority (lowest req index always wins).

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef STRB_SIZE
`define STRB_SIZE 4
`endif

module apb_req_arbiter_lane #(
    parameter int CW = 1
) (
    input  logic          sel,
    input  logic [CW-1:0] cmd,
    output logic [CW-1:0] cmd_sel
);
    assign cmd_sel = sel ? cmd : '0;
endmodule

module apb_req_arbiter #(
    parameter int NREQ       = 4,
    parameter int ADDR_WIDTH = `ADDR_WIDTH,
    parameter int DATA_WIDTH = `DATA_WIDTH,
    parameter int STRB_SIZE  = `STRB_SIZE
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NREQ-1:0]            req,
    input  logic [NREQ-1:0]            wr_i,
    input  logic [NREQ*ADDR_WIDTH-1:0] addr_i,
    input  logic [NREQ*DATA_WIDTH-1:0] wdata_i,
    input  logic [NREQ*STRB_SIZE-1:0]  strb_i,
    output logic [NREQ-1:0]            grant,
    output logic [NREQ-1:0]            ack,
    output logic [DATA_WIDTH-1:0]      rdata_o,
    output logic                       m_trnsfr,
    output logic                       m_wr,
    output logic [ADDR_WIDTH-1:0]      m_address,
    output logic [DATA_WIDTH-1:0]      m_data_in,
    output logic [STRB_SIZE-1:0]       m_strb,
    input  logic                       m_enable,
    input  logic                       m_ready,
    input  logic [DATA_WIDTH-1:0]      m_data_out
);
    localparam int CW = 1 + ADDR_WIDTH + DATA_WIDTH + STRB_SIZE;
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef struct packed {
        logic                  wr;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
        logic [STRB_SIZE-1:0]  strb;
    } cmd_t;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

    state_t                     state, state_nxt;
    cmd_t                       cmd_q;
    logic [DATA_WIDTH-1:0]      rdata_q;
    logic [NREQ-1:0]            pick;
    logic [NREQ-1:0][CW-1:0]    lane_cmd;
    logic [CW-1:0]              cmd_pick;

    // Each lane masks its own command with the one-hot pick; the OR gives the winner.
    for (genvar g = 0; g < NREQ; g++) begin : g_lane
        cmd_t cmd_in;
        assign cmd_in.wr   = wr_i[g];
        assign cmd_in.addr = addr_i[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign cmd_in.data = wdata_i[g*DATA_WIDTH +: DATA_WIDTH];
        assign cmd_in.strb = strb_i[g*STRB_SIZE +: STRB_SIZE];

        apb_req_arbiter_lane #(.CW(CW)) u_lane (
            .sel     (pick[g]),
            .cmd     (cmd_in),
            .cmd_sel (lane_cmd[g])
        );
    end

    always_comb begin
        cmd_pick = '0;
        for (int i = 0; i < NREQ; i++)
            cmd_pick = cmd_pick | lane_cmd[i];
    end

`ifdef APB_ARB_FIXED_PRIO_EN
    // Isolate the lowest set request bit.
    assign pick = req & (~req + NREQ'(1));
`else
    logic [IW-1:0] last_grant;
    logic [IW-1:0] owner;
    logic          found;

    always_comb begin
        pick  = '0;
        found = 1'b0;
        for (int i = 1; i <= NREQ; i++) begin
            if (!found && req[IW'((int'(last_grant) + i) % NREQ)]) begin
                pick[IW'((int'(last_grant) + i) % NREQ)] = 1'b1;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        owner = '0;
        for (int i = 0; i < NREQ; i++)
            if (grant[i]) owner = IW'(i);
    end

    // Pointer moves only on completion, so an aborted transfer does not consume a turn.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last_grant <= IW'(NREQ - 1);
        else if (state == ACK)
            last_grant <= owner;
    end
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (|req) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (m_enable && m_ready) state_nxt = ACK;
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            grant   <= '0;
            cmd_q   <= '0;
            rdata_q <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (|req) begin
                    grant <= pick;
                    cmd_q <= cmd_pick;
                end
                WAIT: if (m_enable && m_ready)
                    rdata_q <= cmd_q.wr ? '0 : m_data_out;
                ACK: begin
                    grant   <= '0;
                    cmd_q   <= '0;
                    rdata_q <= '0;
                end
                default: ;
            endcase
        end
    end

    assign m_trnsfr  = (state == ISSUE);
    assign ack       = (state == ACK) ? grant : '0;
    assign rdata_o   = rdata_q;
    assign m_wr      = cmd_q.wr;
    assign m_address = cmd_q.addr;
    assign m_data_in = cmd_q.data;
    assign m_strb    = cmd_q.strb;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Directed bench for apb_req_arbiter with a small APB slave model (configurable wait states).
// Expected grant order follows APB_ARB_FIXED_PRIO_EN when it is defined.

module tb_apb_req_arbiter;
    localparam int NREQ = 4;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int SW   = 4;

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic [NREQ-1:0]           req, wr_i, grant, ack;
    logic [NREQ-1:0][AW-1:0]   addr_i;
    logic [NREQ-1:0][DW-1:0]   wdata_i;
    logic [NREQ-1:0][SW-1:0]   strb_i;
    logic [DW-1:0]             rdata_o, m_data_in, m_data_out;
    logic                      m_trnsfr, m_wr, m_enable, m_ready;
    logic [AW-1:0]             m_address;
    logic [SW-1:0]             m_strb;

    always #5 clk = ~clk;

    apb_req_arbiter #(.NREQ(NREQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_SIZE(SW)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .wr_i(wr_i), .addr_i(addr_i),
        .wdata_i(wdata_i), .strb_i(strb_i), .grant(grant), .ack(ack), .rdata_o(rdata_o),
        .m_trnsfr(m_trnsfr), .m_wr(m_wr), .m_address(m_address), .m_data_in(m_data_in),
        .m_strb(m_strb), .m_enable(m_enable), .m_ready(m_ready), .m_data_out(m_data_out)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // APB slave model: setup phase the cycle after m_trnsfr, access phase after that.
    int            ws = 0;
    logic [DW-1:0] rd_val = '0;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    int            n_wr;

    initial begin
        m_enable = 1'b0; m_ready = 1'b0; m_data_out = '0;
        wr_addr = '0; wr_data = '0; n_wr = 0;
        forever begin
            @(posedge clk); #1;
            if (m_trnsfr) begin
                @(posedge clk); #1;
                if (m_wr) begin wr_addr = m_address; wr_data = m_data_in; n_wr++; end
                @(posedge clk); #1;
                m_enable = 1'b1; m_ready = 1'b0;
                for (int w = 0; w < ws; w++) begin @(posedge clk); #1; end
                m_ready = 1'b1; m_data_out = rd_val;
                @(posedge clk); #1;
                m_enable = 1'b0; m_ready = 1'b0; m_data_out = '0;
            end
        end
    end

    // Monitor: per-requester ack counts and a log of grant rising edges.
    int              ack_cnt [NREQ];
    int              gcnt;
    logic [NREQ-1:0] glog [64];
    logic [NREQ-1:0] gprev;

    initial begin
        gcnt = 0; gprev = '0;
        for (int i = 0; i < NREQ; i++) ack_cnt[i] = 0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < NREQ; i++) if (ack[i]) ack_cnt[i]++;
            if (grant != '0 && gprev == '0 && gcnt < 64) begin glog[gcnt] = grant; gcnt++; end
            gprev = grant;
        end
    end

    function automatic int ack_total();
        int s = 0;
        for (int i = 0; i < NREQ; i++) s += ack_cnt[i];
        return s;
    endfunction

    initial begin
        int a0, g0, budget, g123;
        int exp_ord [5];
        logic stable, early;

        req = '0; wr_i = '0; addr_i = '0; wdata_i = '0; strb_i = '0; rst_n = 1'b0;
        cyc(2);
        chk("rst_grant", grant, 0);
        chk("rst_trnsfr", m_trnsfr, 0);
        chk("rst_addr", m_address, 0);
        chk("rst_rdata", rdata_o, 0);
        rst_n = 1'b1;
        cyc(2);
        chk("idle_grant", grant, 0);

        // Single zero-wait write from requester 2
        ws = 0; rd_val = 32'h5555_5555;
        req = 4'b0100; wr_i = 4'b0100; addr_i[2] = 32'h10; wdata_i[2] = 32'hA5A5_A5A5; strb_i[2] = 4'hF;
        cyc(1);
        chk("wr_grant", grant, 4'b0100);
        chk("wr_trnsfr", m_trnsfr, 1);
        chk("wr_m_wr", m_wr, 1);
        chk("wr_addr", m_address, 32'h10);
        chk("wr_data", m_data_in, 32'hA5A5_A5A5);
        chk("wr_strb", m_strb, 4'hF);
        cyc(1);
        chk("wr_trnsfr_once", m_trnsfr, 0);
        cyc(1);
        chk("wr_no_early_ack", ack, 0);
        cyc(1);
        chk("wr_ack", ack, 4'b0100);
        chk("wr_rdata_zero", rdata_o, 0);
        req = '0;
        cyc(1);
        chk("wr_grant_clr", grant, 0);
        chk("wr_idle_addr", m_address, 0);
        chk("slave_wr_addr", wr_addr, 32'h10);
        chk("slave_wr_data", wr_data, 32'hA5A5_A5A5);
        cyc(2);

        // Read with three wait states from requester 1
        ws = 3; rd_val = 32'hDEAD_BEEF;
        req = 4'b0010; wr_i = '0; addr_i[1] = 32'h20;
        stable = 1'b1; early = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            cyc(1);
            if (k == 1) chk("rd_grant", grant, 4'b0010);
            if (m_address !== 32'h20) stable = 1'b0;
            if (k < 7 && ack !== '0) early = 1'b1;
        end
        chk("rd_ack", ack, 4'b0010);
        chk("rd_rdata", rdata_o, 32'hDEAD_BEEF);
        chk("rd_addr_stable", stable, 1);
        chk("rd_no_early_ack", early, 0);
        req = '0;
        cyc(3);
        chk("rd_rdata_clr", rdata_o, 0);

        // Requester 1 drops req right after grant
        ws = 0; a0 = ack_cnt[1];
        req = 4'b0010; wr_i = 4'b0010; addr_i[1] = 32'h24; wdata_i[1] = 32'h1234;
        cyc(1);
        chk("drop_grant", grant, 4'b0010);
        req = '0;
        cyc(3);
        chk("drop_ack", ack, 4'b0010);
        cyc(3);
        chk("drop_ack_once", ack_cnt[1] - a0, 1);
        chk("drop_idle", grant, 0);

        // Reset during WAIT
        req = 4'b0001; wr_i = '0; addr_i[0] = 32'h40;
        cyc(1);
        chk("pre_rst_grant", grant, 4'b0001);
        cyc(1);
        a0 = ack_total();
        rst_n = 1'b0; #1;
        chk("midrst_grant", grant, 0);
        chk("midrst_trnsfr", m_trnsfr, 0);
        chk("midrst_addr", m_address, 0);
        req = '0;
        cyc(2);
        rst_n = 1'b1;
        cyc(5);
        chk("midrst_no_ack", ack_total() - a0, 0);

        // After reset index 0 beats index 3
        req = 4'b1001; addr_i[3] = 32'h30;
        cyc(1);
        chk("post_rst_prio0", grant, 4'b0001);
        cyc(3);
        chk("post_rst_ack0", ack, 4'b0001);
        req = '0;
        cyc(2);
        rst_n = 1'b0;
        cyc(1);
        rst_n = 1'b1;
        cyc(2);
        req = 4'b1000;
        cyc(1);
        chk("post_rst_req3", grant, 4'b1000);
        req = '0;
        cyc(3);
        chk("post_rst_ack3", ack, 4'b1000);
        cyc(2);

        // All four requesting continuously
`ifdef APB_ARB_FIXED_PRIO_EN
        exp_ord = '{1, 1, 1, 1, 1};
`else
        exp_ord = '{1, 2, 4, 8, 1};
`endif
        g0 = gcnt; a0 = ack_total(); budget = 0;
        req = 4'b1111; wr_i = '0;
        while (gcnt - g0 < 5 && budget < 100) begin cyc(1); budget++; end
        req = '0;
        cyc(10);
        chk("multi_gcnt", gcnt - g0, 5);
        g123 = 0;
        for (int k = 0; k < 5; k++) begin
            chk("multi_order", glog[g0 + k], exp_ord[k][NREQ-1:0]);
            if (glog[g0 + k][3:1] != 3'b000) g123++;
        end
`ifdef APB_ARB_FIXED_PRIO_EN
        chk("multi_others_never", g123, 0);
`else
        chk("multi_others_served", g123, 3);
`endif
        chk("multi_acks", ack_total() - a0, 5);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/apb_req_arbiter.md
APB_REQ_ARBITER -- requirements
Module: apb_req_arbiter

Interface
REQ-001 The block SHALL have these parameters, one per line as name, default, meaning:
- NREQ, 4, number of requesters (2..8)
- ADDR_WIDTH, `ADDR_WIDTH, address width
- DATA_WIDTH, `DATA_WIDTH, data width
- STRB_SIZE, `STRB_SIZE, strobe width
REQ-002 The block SHALL have these ports, one per line as name, direction, width, meaning:
- clk  in  1  clock; the block has one clock
- rst_n  in  1  reset, asynchronous, active-low
- req  in  NREQ  per-requester transfer request
- wr_i  in  NREQ  per-requester write(1)/read(0)
- addr_i  in  NREQ*ADDR_WIDTH  per-requester address, packed, index 0 in the LSBs
- wdata_i  in  NREQ*DATA_WIDTH  per-requester write data, packed
- strb_i  in  NREQ*STRB_SIZE  per-requester strobes, packed
- grant  out  NREQ  one-hot owner of the in-flight transfer
- ack  out  NREQ  one-cycle completion pulse to the owner
- rdata_o  out  DATA_WIDTH  read data, valid with ack
- m_trnsfr  out  1  transfer strobe to the APB master
- m_wr, m_address, m_data_in, m_strb  out  1/ADDR/DATA/STRB  command to the APB master
- m_enable, m_ready  in  1  APB penable/pready observed at the master
- m_data_out  in  DATA_WIDTH  read data returned by the APB master

Function
REQ-003 The block SHALL implement the states IDLE, ISSUE, WAIT and ACK.
REQ-004 IDLE: if any req bit is set, the block SHALL register a one-hot grant per REQ-009 and go to ISSUE; otherwise it SHALL stay in IDLE with grant=0.
REQ-005 ISSUE: the block SHALL drive m_trnsfr=1 for exactly one cycle, then go to WAIT.
REQ-006 WAIT: the block SHALL hold m_trnsfr=0 and go to ACK in the cycle after m_enable&m_ready=1. Wait states (m_ready=0) SHALL extend WAIT indefinitely.
REQ-007 ACK:
- ack[owner] SHALL be 1 for one cycle.
- rdata_o SHALL be m_data_out registered at completion for reads, and 0 for writes.
- The block SHALL clear grant, update the pointer and return to IDLE.
REQ-008 From ISSUE through ACK, m_wr, m_address, m_data_in and m_strb SHALL be the owner's command captured at grant, and SHALL stay stable. In IDLE they SHALL be 0.
REQ-009 Arbitration SHALL be round-robin:
- Search starts at index last_grant+1 and wraps at NREQ-1 to 0.
- The first set req bit wins.
- last_grant SHALL update only in ACK.
REQ-010 A requester SHALL hold req and its command until ack. A req dropped before grant is ignored. A req dropped after grant SHALL NOT abort the transfer, and ack still pulses.
REQ-011 A requester still asserting req in ACK SHALL NOT be granted in that cycle. Re-arbitration happens in IDLE only, so the minimum gap between grants is one IDLE cycle.
REQ-012 Latency for a zero-wait slave, with req rising in IDLE at cycle T: grant at T+1, m_trnsfr at T+1, ack at T+4.
REQ-013 Simultaneous requests SHALL be served one per transfer, with no requester starved for more than NREQ-1 transfers.

Reset
REQ-014 On rst_n=0, at any time including mid-transfer, the block SHALL immediately go to IDLE with grant=0, ack=0, m_trnsfr=0, rdata_o=0 and all m_* command outputs 0.
REQ-015 On reset, last_grant SHALL be set to NREQ-1, so that index 0 has first priority after reset.
REQ-016 No ack SHALL be produced for a transfer interrupted by reset.

Configuration
REQ-017 When macro APB_ARB_FIXED_PRIO_EN is defined, arbitration SHALL be fixed priority: the lowest set req index always wins and last_grant is unused.
REQ-018 When APB_ARB_FIXED_PRIO_EN is undefined, round-robin per REQ-009 applies. All other behaviour SHALL be identical in both cases.

Verification
REQ-019 Single write: req[2]=1, wr=1, addr=0x10, wdata=0xA5A5A5A5, strb=0xF, zero-wait slave -> grant=0b0100 at T+1, m_trnsfr pulse at T+1, ack[2] at T+4, slave writes 0xA5A5A5A5 at address 0x10.
REQ-020 Read with 3 wait states: req[1] read of addr 0x20, slave returns 0xDEADBEEF -> ack[1] at T+7 with rdata_o=0xDEADBEEF, and m_address=0x20 stable from T+1 to T+7.
REQ-021 All four req held continuously (round-robin) -> grant order 0,1,2,3,0 with exactly one ack per grant.
REQ-022 Same stimulus with APB_ARB_FIXED_PRIO_EN defined -> grant order 0,0,0 and requesters 1..3 never granted.
REQ-023 Reset mid-transfer: rst_n low during WAIT -> the same cycle shows grant=0 and m_trnsfr=0, no ack follows, and after release req[3]=1 is granted before req[0] only if req[0]=0.
REQ-024 req[1] dropped one cycle after grant -> transfer completes and ack[1] still pulses once.
